// File: rtl/branch_resolver_bht.sv
// Branch unit: resolves the branch condition, predicts direction from a table of 2-bit
// saturating counters indexed by PC, trains the table on resolution and keeps saturating statistics.
module branch_resolver_bht #(
  parameter int WIDTH     = 16,
  parameter int PC_WIDTH  = 16,
  parameter int ENTRIES   = 16,
  parameter int INDEX_LSB = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pred_req,
  input  logic [PC_WIDTH-1:0]  pred_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  input  logic                 res_req,
  input  logic [PC_WIDTH-1:0]  res_pc,
  input  logic                 branch,
  input  logic [2:0]           branch_funct,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 res_pred_taken,
  output logic                 res_valid,
  output logic                 taken,
  output logic                 mispredict,
  input  logic                 clr_stats,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [1:0]       bht [ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cond;
  logic             legal;
  logic             taken_c;
  logic             mispred_c;
  logic             train;
  logic             count;
  logic             unused_pc;

  assign pred_idx  = pred_pc[INDEX_LSB +: IDX_W];
  assign res_idx   = res_pc[INDEX_LSB +: IDX_W];
  assign unused_pc = ^{pred_pc, res_pc};

  always_comb begin
    cond = 1'b0;
    case (branch_funct)
      3'b000:  cond = (op_a == op_b);
      3'b001:  cond = (op_a != op_b);
      3'b010:  cond = ($signed(op_a) <  $signed(op_b));
      3'b011:  cond = ($signed(op_a) >= $signed(op_b));
      3'b100:  cond = (op_a <  op_b);
      3'b101:  cond = (op_a >= op_b);
      default: cond = 1'b0;
    endcase
  end

  // Codes 110/111 resolve not-taken and never touch the table, but still count as branches.
  assign legal     = (branch_funct[2:1] != 2'b11);
  assign taken_c   = branch & legal & cond;
  assign mispred_c = taken_c ^ res_pred_taken;
  assign train     = res_req & branch & legal;
  assign count     = res_req & branch;

  // Non-blocking update gives read-before-write for a same-cycle predict on the same index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (train) begin
      if (taken_c && bht[res_idx] != 2'b11)
        bht[res_idx] <= bht[res_idx] + 2'd1;
      else if (!taken_c && bht[res_idx] != 2'b00)
        bht[res_idx] <= bht[res_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      res_valid  <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      pred_valid <= pred_req;
      res_valid  <= res_req;
      if (pred_req) pred_taken <= bht[pred_idx][1];
      if (res_req) begin
        taken      <= taken_c;
        mispredict <= mispred_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (count) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if (mispred_c && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver_bht.sv
// Self-checking bench for branch_resolver_bht: a reference model pushes expected results
// into queues as requests are driven, and each scenario pops and compares them.
module tb_branch_resolver_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_req;
  logic [15:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        res_req;
  logic [15:0] res_pc;
  logic        branch;
  logic [2:0]  branch_funct;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        res_pred_taken;
  logic        res_valid;
  logic        taken;
  logic        mispredict;
  logic        clr_stats;
  logic [3:0]  branch_cnt;
  logic [3:0]  mispred_cnt;

  typedef struct packed {
    logic taken;
    logic misp;
  } res_t;

  res_t       exp_res[$];
  logic       exp_pred[$];
  logic [1:0] m_tbl [16];
  logic [3:0] m_bcnt;
  logic [3:0] m_mcnt;
  int         checks = 0;
  int         errors = 0;

  branch_resolver_bht #(.CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_req(res_req), .res_pc(res_pc), .branch(branch), .branch_funct(branch_funct),
    .op_a(op_a), .op_b(op_b), .res_pred_taken(res_pred_taken),
    .res_valid(res_valid), .taken(taken), .mispredict(mispredict),
    .clr_stats(clr_stats), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    logic sa_lt_b;
    // signed compare derived from sign bits so it does not reuse the DUT's $signed form
    if (a[15] != b[15]) sa_lt_b = a[15];
    else                sa_lt_b = (a < b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b010:  return sa_lt_b;
      3'b011:  return !sa_lt_b;
      3'b100:  return a < b;
      3'b101:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
    m_bcnt = '0;
    m_mcnt = '0;
    exp_res.delete();
    exp_pred.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pred_req  = 1'b0;
    res_req   = 1'b0;
    clr_stats = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_pred(input logic [15:0] pc);
    pred_req = 1'b1;
    pred_pc  = pc;
    exp_pred.push_back(m_tbl[pc[4:1]][1]);
  endtask

  task automatic drive_clr();
    clr_stats = 1'b1;
    m_bcnt = '0;
    m_mcnt = '0;
  endtask

  task automatic drive_res(input logic [15:0] pc, input logic br, input logic [2:0] f,
                           input logic [15:0] a, input logic [15:0] b, input logic pt);
    logic       t;
    logic       m;
    logic [3:0] i;
    res_req = 1'b1; res_pc = pc; branch = br; branch_funct = f;
    op_a = a; op_b = b; res_pred_taken = pt;
    t = br && ref_cond(f, a, b);
    m = t ^ pt;
    exp_res.push_back(res_t'({t, m}));
    i = pc[4:1];
    if (br && f[2:1] != 2'b11) begin
      if (t && m_tbl[i] != 2'b11)       m_tbl[i] = m_tbl[i] + 2'd1;
      else if (!t && m_tbl[i] != 2'b00) m_tbl[i] = m_tbl[i] - 2'd1;
    end
    if (br && !clr_stats) begin
      if (m_bcnt != 4'hF) m_bcnt = m_bcnt + 4'd1;
      if (m && m_mcnt != 4'hF) m_mcnt = m_mcnt + 4'd1;
    end
  endtask

  task automatic test_reset();
    logic ep;
    rst_n = 1'b0;
    pred_req = 1'b1; pred_pc = 16'h0; res_req = 1'b1; res_pc = 16'h0;
    branch = 1'b1; branch_funct = 3'b000; op_a = 16'h1; op_b = 16'h1; res_pred_taken = 1'b0;
    tick();
    tick();
    checks++;
    if ({pred_valid, pred_taken, res_valid, taken, mispredict} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b%b%b%b%b want 00000", pred_valid, pred_taken, res_valid, taken, mispredict);
    end
    checks++;
    if (branch_cnt !== 4'h0 || mispred_cnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", branch_cnt, mispred_cnt);
    end
    rst_n = 1'b1;
    model_reset();
    drive_pred(16'h0000);
    tick();
    ep = exp_pred.pop_front();
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== ep || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_pred: got v=%b t=%b want v=1 t=%b", pred_valid, pred_taken, ep);
    end
  endtask

  task automatic test_funct();
    logic [2:0]  fv [8] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b011, 3'b101, 3'b011, 3'b010};
    logic [15:0] av [8] = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'h1234, 16'h8000, 16'h8000, 16'h0005, 16'h7FFF};
    logic [15:0] bv [8] = '{16'h0001, 16'h0001, 16'h1234, 16'h1234, 16'h7FFF, 16'h7FFF, 16'h0005, 16'h8000};
    res_t e;
    for (int k = 0; k < 8; k++) begin
      drive_res(16'h0006, 1'b1, fv[k], av[k], bv[k], 1'b0);
      tick();
      e = exp_res.pop_front();
      checks++;
      if (res_valid !== 1'b1 || taken !== e.taken || mispredict !== e.misp) begin
        errors++;
        $display("FAIL funct_%0d: got v=%b t=%b m=%b want v=1 t=%b m=%b", k, res_valid, taken, mispredict, e.taken, e.misp);
      end
      if (k == 0) begin
        checks++;
        if (taken !== 1'b1 || mispredict !== 1'b1) begin
          errors++;
          $display("FAIL blt_signed: got t=%b m=%b want t=1 m=1", taken, mispredict);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0 || taken !== 1'b1) begin
          errors++;
          $display("FAIL hold_idle: got v=%b t=%b want v=0 t=1", res_valid, taken);
        end
      end
      if (k == 1) begin
        checks++;
        if (taken !== 1'b0) begin
          errors++;
          $display("FAIL bltu_unsigned: got t=%b want t=0", taken);
        end
      end
    end
  endtask

  task automatic test_train();
    logic dir [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic want [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic ep;
    res_t e;
    for (int k = 0; k < 5; k++) begin
      drive_res(16'h0010, 1'b1, 3'b000, 16'h0003, dir[k] ? 16'h0003 : 16'h0004, 1'b0);
      tick();
      e = exp_res.pop_front();
      checks++;
      if (res_valid !== 1'b1 || taken !== e.taken) begin
        errors++;
        $display("FAIL train_res_%0d: got v=%b t=%b want v=1 t=%b", k, res_valid, taken, e.taken);
      end
      drive_pred(16'h0010);
      tick();
      ep = exp_pred.pop_front();
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== ep || pred_taken !== want[k]) begin
        errors++;
        $display("FAIL train_pred_%0d: got v=%b t=%b want v=1 t=%b", k, pred_valid, pred_taken, want[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ep;
    res_t e;
    drive_pred(16'h0004);
    drive_res(16'h0004, 1'b1, 3'b000, 16'h0009, 16'h0009, 1'b0);
    tick();
    ep = exp_pred.pop_front();
    e = exp_res.pop_front();
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== ep || pred_taken !== 1'b0 || res_valid !== 1'b1 || taken !== e.taken) begin
      errors++;
      $display("FAIL rbw_same_cycle: got pv=%b pt=%b rv=%b t=%b want 1 0 1 %b", pred_valid, pred_taken, res_valid, taken, e.taken);
    end
    drive_pred(16'h0004);
    tick();
    ep = exp_pred.pop_front();
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== ep || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL rbw_next_cycle: got v=%b t=%b want v=1 t=1", pred_valid, pred_taken);
    end
  endtask

  task automatic test_illegal();
    logic ep;
    res_t e;
    logic [2:0]  fv [3] = '{3'b110, 3'b000, 3'b111};
    logic        bv [3] = '{1'b1, 1'b0, 1'b1};
    logic        pv [3] = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      drive_res(16'h000C, bv[k], fv[k], 16'h0007, 16'h0007, pv[k]);
      tick();
      e = exp_res.pop_front();
      checks++;
      if (res_valid !== 1'b1 || taken !== 1'b0 || taken !== e.taken || mispredict !== e.misp || mispredict !== pv[k]) begin
        errors++;
        $display("FAIL illegal_res_%0d: got v=%b t=%b m=%b want v=1 t=0 m=%b", k, res_valid, taken, mispredict, pv[k]);
      end
      checks++;
      if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin
        errors++;
        $display("FAIL illegal_cnt_%0d: got %0d/%0d want %0d/%0d", k, branch_cnt, mispred_cnt, m_bcnt, m_mcnt);
      end
      drive_pred(16'h000C);
      tick();
      ep = exp_pred.pop_front();
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== ep || pred_taken !== 1'b0) begin
        errors++;
        $display("FAIL illegal_table_%0d: got v=%b t=%b want v=1 t=0", k, pred_valid, pred_taken);
      end
    end
  endtask

  task automatic test_stats();
    res_t e;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      drive_res(16'h001E, 1'b1, 3'b000, 16'h0005, 16'h0005, 1'b0);
      tick();
      e = exp_res.pop_front();
      checks++;
      if (res_valid !== 1'b1 || taken !== e.taken || mispredict !== e.misp || branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin
        errors++;
        $display("FAIL stats_%0d: got t=%b m=%b cnt=%0d/%0d want t=%b m=%b cnt=%0d/%0d",
                 k, taken, mispredict, branch_cnt, mispred_cnt, e.taken, e.misp, m_bcnt, m_mcnt);
      end
    end
    checks++;
    if (branch_cnt !== 4'hF || mispred_cnt !== 4'hF) begin
      errors++;
      $display("FAIL stats_saturate: got %0d/%0d want 15/15", branch_cnt, mispred_cnt);
    end
    drive_clr();
    drive_res(16'h001E, 1'b1, 3'b000, 16'h0005, 16'h0005, 1'b0);
    tick();
    e = exp_res.pop_front();
    checks++;
    if (branch_cnt !== 4'h0 || mispred_cnt !== 4'h0 || m_bcnt !== 4'h0) begin
      errors++;
      $display("FAIL stats_clear: got %0d/%0d want 0/0", branch_cnt, mispred_cnt);
    end
    drive_res(16'h001E, 1'b1, 3'b001, 16'h0005, 16'h0005, 1'b0);
    tick();
    e = exp_res.pop_front();
    checks++;
    if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt || branch_cnt !== 4'h1 || mispred_cnt !== 4'h0) begin
      errors++;
      $display("FAIL stats_resume: got %0d/%0d want 1/0", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic ep;
    res_t e;
    drive_pred(16'h0010);
    drive_res(16'h0010, 1'b1, 3'b000, 16'h0001, 16'h0001, 1'b0);
    tick();
    ep = exp_pred.pop_front();
    e = exp_res.pop_front();
    checks++;
    if (pred_valid !== 1'b1 || res_valid !== 1'b1 || taken !== e.taken || pred_taken !== ep) begin
      errors++;
      $display("FAIL pre_reset: got pv=%b rv=%b t=%b pt=%b want 1 1 %b %b", pred_valid, res_valid, taken, pred_taken, e.taken, ep);
    end
    rst_n = 1'b0;
    pred_req = 1'b1; pred_pc = 16'h0010;
    res_req = 1'b1; res_pc = 16'h0010; branch = 1'b1; branch_funct = 3'b000;
    op_a = 16'h1; op_b = 16'h1; res_pred_taken = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (pred_valid !== 1'b0 || res_valid !== 1'b0 || branch_cnt !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset: got pv=%b rv=%b cnt=%0d want 0 0 0", pred_valid, res_valid, branch_cnt);
    end
    drive_pred(16'h0010);
    tick();
    ep = exp_pred.pop_front();
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== ep || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_table: got v=%b t=%b want v=1 t=0", pred_valid, pred_taken);
    end
  endtask

  initial begin
    rst_n = 1'b0; pred_req = 1'b0; pred_pc = '0; res_req = 1'b0; res_pc = '0;
    branch = 1'b0; branch_funct = '0; op_a = '0; op_b = '0; res_pred_taken = 1'b0; clr_stats = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_funct();
    test_train();
    test_back_to_back();
    test_illegal();
    test_stats();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
